// File: rtl/srio_swrite_filter.sv
// rtl/srio_swrite_filter.sv - forwards well-formed SWRITE packets and counts pass/drop/length errors.
// Optional address window check enabled by defining SRIO_FILTER_ADDR_EN.
module srio_swrite_filter #(
  parameter int          CNT_W     = 32,
  parameter logic [33:0] ADDR_BASE = 34'h0,
  parameter logic [33:0] ADDR_MASK = 34'h0
) (
  input  logic             AXIS_ACLK,
  input  logic             AXIS_ARESET,
  input  logic [63:0]      S_AXIS_TDATA,
  input  logic             S_AXIS_TVALID,
  input  logic             S_AXIS_TLAST,
  output logic             S_AXIS_TREADY,
  output logic [63:0]      M_AXIS_TDATA,
  output logic             M_AXIS_TVALID,
  output logic             M_AXIS_TLAST,
  input  logic             M_AXIS_TREADY,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_pass,
  output logic [CNT_W-1:0] cnt_drop,
  output logic [CNT_W-1:0] cnt_len_err
`ifdef SRIO_FILTER_ADDR_EN
  ,
  output logic [CNT_W-1:0] cnt_addr_miss
`endif
);

  typedef enum logic [1:0] {HDR, PASS, DROP} state_t;

  state_t     state;
  logic [5:0] beat_cnt;
  logic [5:0] exp_beats;
  logic [5:0] beat_cnt_nxt;
  logic       accept;
  logic       is_swrite;
  logic       addr_ok;
  logic       load;
  logic       inc_pass;
  logic       inc_len;
  logic       inc_drop;

`ifdef SRIO_FILTER_ADDR_EN
  logic inc_miss;
  assign addr_ok  = ((S_AXIS_TDATA[33:0] ^ ADDR_BASE) & ADDR_MASK) == 34'h0;
  assign inc_miss = accept && (state == HDR) && is_swrite && !addr_ok && !S_AXIS_TLAST;
`else
  assign addr_ok = 1'b1;
`endif

  // DROP never touches the slice, so it can sink beats unconditionally.
  assign S_AXIS_TREADY = (state == DROP) || !M_AXIS_TVALID || M_AXIS_TREADY;
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign is_swrite     = S_AXIS_TDATA[55:52] == 4'h6;
  assign beat_cnt_nxt  = (beat_cnt == 6'd63) ? 6'd63 : beat_cnt + 6'd1;

  assign load     = accept && ((state == PASS) ||
                    ((state == HDR) && is_swrite && addr_ok && !S_AXIS_TLAST));
  assign inc_pass = accept && (state == PASS) && S_AXIS_TLAST;
  assign inc_len  = inc_pass && (beat_cnt_nxt != exp_beats);
  assign inc_drop = accept && (state == HDR) && (S_AXIS_TLAST || !(is_swrite && addr_ok));

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c,
                                             input logic inc, input logic clr);
    if (clr) return '0;
    if (inc && (c != '1)) return c + CNT_W'(1);
    return c;
  endfunction

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state         <= HDR;
      beat_cnt      <= 6'd0;
      exp_beats     <= 6'd0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= 64'h0;
      M_AXIS_TLAST  <= 1'b0;
      cnt_pass      <= '0;
      cnt_drop      <= '0;
      cnt_len_err   <= '0;
`ifdef SRIO_FILTER_ADDR_EN
      cnt_addr_miss <= '0;
`endif
    end else begin
      if (load) begin
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TDATA  <= S_AXIS_TDATA;
        M_AXIS_TLAST  <= S_AXIS_TLAST;
      end else if (M_AXIS_TREADY) begin
        M_AXIS_TVALID <= 1'b0;
      end

      if (accept) begin
        case (state)
          HDR: begin
            if (!S_AXIS_TLAST) begin
              if (is_swrite && addr_ok) begin
                exp_beats <= {1'b0, S_AXIS_TDATA[44:40]} + 6'd1;
                beat_cnt  <= 6'd0;
                state     <= PASS;
              end else begin
                state <= DROP;
              end
            end
          end
          PASS: begin
            beat_cnt <= beat_cnt_nxt;
            if (S_AXIS_TLAST) state <= HDR;
          end
          default: begin
            if (S_AXIS_TLAST) state <= HDR;
          end
        endcase
      end

      cnt_pass    <= bump(cnt_pass, inc_pass, clr_cnt);
      cnt_drop    <= bump(cnt_drop, inc_drop, clr_cnt);
      cnt_len_err <= bump(cnt_len_err, inc_len, clr_cnt);
`ifdef SRIO_FILTER_ADDR_EN
      cnt_addr_miss <= bump(cnt_addr_miss, inc_miss, clr_cnt);
`endif
    end
  end

endmodule
